alu_acc: RTL and testbench

ALU_ACC -- requirements
Module: alu_acc

---
 rtl/alu_acc.sv | 135 +++++++++++++
 tb/tb_alu_acc.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc.sv
// rtl/alu_acc.sv - accumulator ALU: single-cycle ops plus a W-step shift-add multiplier.
// RGZ doubles as the accumulator source for INC/DEC/ACC/ACS.
module alu_acc #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ENA,
  input  logic         STB,
  input  logic [3:0]   OPT,
  input  logic [W-1:0] RGA,
  input  logic [W-1:0] RGB,
  output logic [W-1:0] RGZ,
  output logic [3:0]   FLG,
  output logic         BSY,
  output logic         DNE
);

  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [3:0]      opt_q;
  logic [W-1:0]    rga_q;
  logic [2*W-1:0]  prod;

  logic [W-1:0]    op_a, op_b, res;
  logic [W:0]      sum;
  logic            sub_op, c_f, v_f;
  logic [W:0]      mstep;
  logic [2*W-1:0]  prod_nx;
  logic [W-1:0]    mul_lo, mul_hi;

  always_comb begin
    op_a   = RGA;
    op_b   = RGB;
    sub_op = 1'b0;
    case (OPT)
      4'h2: sub_op = 1'b1;
      4'h9: begin op_a = RGZ; op_b = W'(1); end
      4'hA: begin op_a = RGZ; op_b = W'(1); sub_op = 1'b1; end
      4'hB: begin op_a = RGZ; op_b = RGA; end
      4'hC: begin op_a = RGZ; op_b = RGA; sub_op = 1'b1; end
      default: ;
    endcase
    // carry bit of the W+1 result is the borrow when subtracting
    sum = sub_op ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});

    res = RGZ;
    c_f = 1'b0;
    v_f = 1'b0;
    case (OPT)
      4'h0: res = '0;
      4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC: begin
        res = sum[W-1:0];
        c_f = sum[W];
        v_f = sub_op ? ((op_a[W-1] != op_b[W-1]) && (sum[W-1] != op_a[W-1]))
                     : ((op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]));
      end
      4'h3: res = RGA ^ RGB;
      4'h4: res = RGA & RGB;
      4'h5: res = RGA | RGB;
      4'h6: res = ~RGA;
      4'h7: begin res = {RGA[W-2:0], 1'b0}; c_f = RGA[W-1]; end
      4'h8: begin res = {1'b0, RGA[W-1:1]}; c_f = RGA[0]; end
      default: ;
    endcase
  end

  // prod holds {partial sum, remaining multiplier bits}; one bit retires per step
  always_comb begin
    mstep   = {1'b0, prod[2*W-1:W]} + {1'b0, (prod[0] ? rga_q : {W{1'b0}})};
    prod_nx = {mstep, prod[W-1:1]};
    mul_lo  = prod_nx[W-1:0];
    mul_hi  = prod_nx[2*W-1:W];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      opt_q <= '0;
      rga_q <= '0;
      prod  <= '0;
      RGZ   <= '0;
      FLG   <= '0;
      BSY   <= 1'b0;
      DNE   <= 1'b0;
    end else if (ENA) begin
      DNE <= 1'b0;
      case (state)
        IDLE: begin
          if (STB) begin
            opt_q <= OPT;
            rga_q <= RGA;
            if (OPT == 4'hD || OPT == 4'hE) begin
              state <= MUL;
              BSY   <= 1'b1;
              cnt   <= '0;
              prod  <= {{W{1'b0}}, RGB};
            end else begin
              DNE <= 1'b1;
              if (OPT != 4'hF) begin
                RGZ <= res;
                FLG <= {(res == '0), res[W-1], c_f, v_f};
              end
            end
          end
        end
        MUL: begin
          prod <= prod_nx;
          if (cnt == CW'(W-1)) begin
            state <= IDLE;
            BSY   <= 1'b0;
            DNE   <= 1'b1;
            cnt   <= '0;
            if (opt_q == 4'hD) begin
              RGZ <= mul_lo;
              FLG <= {(mul_lo == '0), mul_lo[W-1], |mul_hi, |mul_hi};
            end else begin
              RGZ <= mul_hi;
              FLG <= {(mul_hi == '0), mul_hi[W-1], 1'b0, 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc.sv
// tb/tb_alu_acc.sv - scoreboard bench for alu_acc at W=8.
// Expected {RGZ,FLG} come from an integer-arithmetic model of the opcode table.
module tb_alu_acc;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, ENA, STB;
  logic [3:0]   OPT;
  logic [W-1:0] RGA, RGB, RGZ;
  logic [3:0]   FLG;
  logic         BSY, DNE;

  int n_chk  = 0;
  int n_fail = 0;
  logic [11:0] sb_q[$];
  logic [7:0]  sh_z;
  logic [3:0]  sh_f;

  alu_acc #(.W(W)) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .STB(STB), .OPT(OPT),
    .RGA(RGA), .RGB(RGB), .RGZ(RGZ), .FLG(FLG), .BSY(BSY), .DNE(DNE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, b, z,
                                        input logic [3:0] f);
    int ua, ub, uz, sa, sb, sz, r, s, p;
    bit c, v, ar;
    logic [7:0] rr;
    ua = a; ub = b; uz = z; sa = $signed(a); sb = $signed(b); sz = $signed(z);
    r = 0; s = 0; c = 0; v = 0; ar = 0; p = ua * ub;
    case (op)
      4'h0: r = 0;
      4'h1: begin r = ua + ub; s = sa + sb; ar = 1; end
      4'h2: begin r = ua - ub; s = sa - sb; ar = 1; end
      4'h3: r = ua ^ ub;
      4'h4: r = ua & ub;
      4'h5: r = ua | ub;
      4'h6: r = 255 - ua;
      4'h7: begin r = ua * 2; c = (ua >= 128); end
      4'h8: begin r = ua / 2; c = (ua % 2) == 1; end
      4'h9: begin r = uz + 1; s = sz + 1; ar = 1; end
      4'hA: begin r = uz - 1; s = sz - 1; ar = 1; end
      4'hB: begin r = uz + ua; s = sz + sa; ar = 1; end
      4'hC: begin r = uz - ua; s = sz - sa; ar = 1; end
      4'hD: begin r = p % 256; c = (p / 256) != 0; v = c; end
      4'hE: r = p / 256;
      default: return {z, f};
    endcase
    if (ar) begin
      c = (r < 0) || (r > 255);
      v = (s < -128) || (s > 127);
    end
    rr = r[7:0];
    return {rr, (rr == 8'h00), rr[7], c, v};
  endfunction

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [11:0] e;
    STB = 1'b1; OPT = op; RGA = a; RGB = b;
    e = model(op, a, b, sh_z, sh_f);
    sb_q.push_back(e);
    sh_z = e[11:4];
    sh_f = e[3:0];
    cycle();
  endtask

  task automatic pop_exp(output logic [11:0] e);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = 'x;
  endtask

  task automatic wait_dne(output int k, output int nb);
    k = 1; nb = 0;
    while (!DNE && k < 40) begin
      if (BSY) nb++;
      cycle();
      k++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; ENA = 1'b0; STB = 1'b1; OPT = 4'h1; RGA = 8'h55; RGB = 8'h55;
    cycle(); cycle();
    n_chk++;
    if ({RGZ, FLG, BSY, DNE} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_state: got RGZ=%h FLG=%b BSY=%b DNE=%b, expected all zero", RGZ, FLG, BSY, DNE);
    end
    RST = 1'b0; ENA = 1'b1; STB = 1'b0;
    sh_z = 8'h00; sh_f = 4'h0; sb_q.delete();
  endtask

  task automatic test_add();
    logic [11:0] e;
    issue(4'h1, 8'h7F, 8'h01);
    STB = 1'b0;
    pop_exp(e);
    n_chk++;
    if ({DNE, BSY, RGZ, FLG} !== {1'b1, 1'b0, e}) begin
      n_fail++;
      $display("FAIL add_sb: got DNE=%b BSY=%b %h/%b, expected 1 0 %h/%b", DNE, BSY, RGZ, FLG, e[11:4], e[3:0]);
    end
    n_chk++;
    if ({RGZ, FLG} !== {8'h80, 4'b0101}) begin
      n_fail++;
      $display("FAIL add_value: got %h/%b, expected 80/0101", RGZ, FLG);
    end
    cycle();
    n_chk++;
    if (DNE !== 1'b0) begin
      n_fail++;
      $display("FAIL add_dne_pulse: DNE=%b, expected 0", DNE);
    end
  endtask

  task automatic test_sub_inc();
    logic [11:0] e;
    logic [11:0] want [3];
    want[0] = {8'hFF, 4'b0110};
    want[1] = {8'h00, 4'b1010};
    want[2] = {8'h01, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) issue(4'h2, 8'h00, 8'h01);
      else issue(4'h9, 8'h00, 8'h00);
      pop_exp(e);
      n_chk++;
      if ({DNE, RGZ, FLG} !== {1'b1, e} || {RGZ, FLG} !== want[i]) begin
        n_fail++;
        $display("FAIL sub_inc_%0d: got DNE=%b %h/%b, expected 1 %h/%b", i, DNE, RGZ, FLG, want[i][11:4], want[i][3:0]);
      end
    end
    STB = 1'b0;
  endtask

  task automatic test_mul();
    logic [11:0] e;
    int k, nb;
    issue(4'hD, 8'h12, 8'h34);
    STB = 1'b0;
    wait_dne(k, nb);
    n_chk++;
    if (k != 9 || nb != 8 || BSY !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_timing: DNE at cycle %0d, BSY cycles %0d, BSY=%b, expected 9 8 0", k, nb, BSY);
    end
    pop_exp(e);
    n_chk++;
    if ({RGZ, FLG} !== e || {RGZ, FLG[1:0]} !== {8'hA8, 2'b11}) begin
      n_fail++;
      $display("FAIL mul_value: got %h/%b, expected %h/%b", RGZ, FLG, e[11:4], e[3:0]);
    end
    cycle();
    n_chk++;
    if (DNE !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_dne_pulse: DNE=%b, expected 0", DNE);
    end
    issue(4'hE, 8'h12, 8'h34);
    STB = 1'b0;
    wait_dne(k, nb);
    pop_exp(e);
    n_chk++;
    if (k != 9 || {RGZ, FLG} !== e || {RGZ, FLG} !== {8'h03, 4'b0000}) begin
      n_fail++;
      $display("FAIL mulh_value: cycle %0d got %h/%b, expected 9 03/0000", k, RGZ, FLG);
    end
  endtask

  task automatic test_acc_b2b();
    logic [11:0] e;
    logic [7:0] want [4];
    int k, bad;
    want[0] = 8'h00; want[1] = 8'h05; want[2] = 8'h0A; want[3] = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) issue(4'h0, 8'h33, 8'h44);
      else issue(4'hB, 8'h05, 8'h00);
      pop_exp(e);
      n_chk++;
      if ({DNE, RGZ, FLG} !== {1'b1, e} || RGZ !== want[i]) begin
        n_fail++;
        $display("FAIL acc_b2b_%0d: got DNE=%b %h/%b, expected 1 %h/%b", i, DNE, RGZ, FLG, want[i], e[3:0]);
      end
    end
    issue(4'hD, 8'h02, 8'h03);
    OPT = 4'h1; RGA = 8'hFF; RGB = 8'hFF;
    k = 1; bad = 0;
    while (!DNE && k < 40) begin
      if (RGZ !== 8'h0F || BSY !== 1'b1) bad++;
      cycle();
      k++;
    end
    STB = 1'b0;
    n_chk++;
    if (k != 9 || bad != 0) begin
      n_fail++;
      $display("FAIL busy_ignore: DNE at cycle %0d, %0d bad busy cycles, expected 9 0", k, bad);
    end
    pop_exp(e);
    n_chk++;
    if ({RGZ, FLG} !== e) begin
      n_fail++;
      $display("FAIL busy_mul_value: got %h/%b, expected %h/%b", RGZ, FLG, e[11:4], e[3:0]);
    end
    cycle();
    n_chk++;
    if (DNE !== 1'b0 || RGZ !== 8'h06) begin
      n_fail++;
      $display("FAIL busy_no_queue: DNE=%b RGZ=%h, expected 0 06", DNE, RGZ);
    end
  endtask

  task automatic test_rst_mul();
    logic [11:0] e;
    int nd;
    issue(4'hD, 8'h12, 8'h34);
    STB = 1'b0;
    cycle(); cycle(); cycle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    sb_q.delete(); sh_z = 8'h00; sh_f = 4'h0;
    n_chk++;
    if ({RGZ, FLG, BSY, DNE} !== 14'h0) begin
      n_fail++;
      $display("FAIL rst_abort: got RGZ=%h FLG=%b BSY=%b DNE=%b, expected all zero", RGZ, FLG, BSY, DNE);
    end
    issue(4'h1, 8'h02, 8'h03);
    STB = 1'b0;
    pop_exp(e);
    n_chk++;
    if ({DNE, RGZ, FLG} !== {1'b1, e} || RGZ !== 8'h05) begin
      n_fail++;
      $display("FAIL rst_then_add: got DNE=%b %h/%b, expected 1 05/%b", DNE, RGZ, FLG, e[3:0]);
    end
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (DNE !== 1'b0) nd++;
    end
    n_chk++;
    if (nd != 0) begin
      n_fail++;
      $display("FAIL rst_no_late_dne: %0d DNE cycles, expected 0", nd);
    end
  endtask

  task automatic test_ena_stall();
    logic [11:0] e;
    int k, bad;
    issue(4'hD, 8'h12, 8'h34);
    STB = 1'b0;
    k = 1; bad = 0;
    while (!DNE && k < 40) begin
      ENA = !(k >= 3 && k < 6);
      if (k == 3) begin RGA = 8'hFF; RGB = 8'hFF; end
      if (!ENA && (BSY !== 1'b1 || DNE !== 1'b0)) bad++;
      cycle();
      k++;
    end
    ENA = 1'b1;
    n_chk++;
    if (k != 12 || bad != 0) begin
      n_fail++;
      $display("FAIL ena_stall_timing: DNE at cycle %0d, %0d bad stall cycles, expected 12 0", k, bad);
    end
    pop_exp(e);
    n_chk++;
    if ({RGZ, FLG} !== e || RGZ !== 8'hA8) begin
      n_fail++;
      $display("FAIL ena_stall_value: got %h/%b, expected %h/%b", RGZ, FLG, e[11:4], e[3:0]);
    end
  endtask

  task automatic test_ena_hold();
    logic [11:0] e;
    int bad;
    issue(4'h5, 8'hF0, 8'h0F);
    pop_exp(e);
    n_chk++;
    if ({DNE, RGZ, FLG} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL hold_or: got DNE=%b %h/%b, expected 1 %h/%b", DNE, RGZ, FLG, e[11:4], e[3:0]);
    end
    ENA = 1'b0; OPT = 4'h0;
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (DNE !== 1'b1 || RGZ !== 8'hFF || BSY !== 1'b0) bad++;
    end
    ENA = 1'b1; STB = 1'b0;
    cycle();
    n_chk++;
    if (bad != 0 || DNE !== 1'b0 || RGZ !== 8'hFF) begin
      n_fail++;
      $display("FAIL ena_hold: %0d bad hold cycles, then DNE=%b RGZ=%h, expected 0 0 FF", bad, DNE, RGZ);
    end
  endtask

  task automatic test_all_ops();
    logic [11:0] e;
    logic [7:0] a, b;
    int k, nb;
    for (int rep = 0; rep < 3; rep++) begin
      for (int op = 0; op < 16; op++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        issue(4'(op), a, b);
        STB = 1'b0;
        k = 1;
        if (op == 13 || op == 14) wait_dne(k, nb);
        pop_exp(e);
        n_chk++;
        if ({DNE, RGZ, FLG} !== {1'b1, e}) begin
          n_fail++;
          $display("FAIL op_%h a=%h b=%h: got DNE=%b %h/%b, expected 1 %h/%b", op, a, b, DNE, RGZ, FLG, e[11:4], e[3:0]);
        end
      end
    end
    issue(4'h0, 8'h00, 8'h00);
    issue(4'hA, 8'h00, 8'h00);
    STB = 1'b0;
    pop_exp(e);
    pop_exp(e);
    n_chk++;
    if ({DNE, RGZ, FLG} !== {1'b1, e} || {RGZ, FLG} !== {8'hFF, 4'b0110}) begin
      n_fail++;
      $display("FAIL dec_wrap: got DNE=%b %h/%b, expected 1 FF/0110", DNE, RGZ, FLG);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; ENA = 1'b0; STB = 1'b0; OPT = 4'h0; RGA = 8'h00; RGB = 8'h00;
    sh_z = 8'h00; sh_f = 4'h0;
    test_reset();
    test_add();
    test_sub_inc();
    test_mul();
    test_acc_b2b();
    test_rst_mul();
    test_ena_stall();
    test_ena_hold();
    test_all_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
